// File: rtl/uart_rx_engine_if.sv
// Processor-side bus of the UART receiver: the received byte, its status flags
// and the READ acknowledge.
interface uart_rx_engine_if;
   logic       READ;
   logic [7:0] UART_DATA;
   logic       RXRDY;
   logic       PERR;
   logic       FERR;
   logic       OVF;

   modport master (output READ, input UART_DATA, RXRDY, PERR, FERR, OVF);
   modport slave  (input READ, output UART_DATA, RXRDY, PERR, FERR, OVF);
endinterface

// File: rtl/uart_rx_engine.sv
// UART receiver: synchronizes RX, centre-samples start/data/parity/stop bits at the
// selected baud rate, and presents the byte with RXRDY/PERR/FERR/OVF to the processor.
module uart_rx_engine (
   input  logic            clk,
   input  logic            reset,
   input  logic            RX,
   input  logic [3:0]      BAUD,
   input  logic            EIGHT,
   input  logic            PEN,
   input  logic            OHEL,
   uart_rx_engine_if.slave bus
);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

   function automatic logic [18:0] bit_time_f(input logic [3:0] code);
      case (code)
         4'd0:    return 19'd333333;
         4'd1:    return 19'd166667;
         4'd2:    return 19'd83333;
         4'd3:    return 19'd41667;
         4'd4:    return 19'd20833;
         4'd5:    return 19'd10417;
         4'd6:    return 19'd5208;
         4'd7:    return 19'd2604;
         4'd8:    return 19'd1736;
         4'd9:    return 19'd868;
         4'd10:   return 19'd434;
         4'd11:   return 19'd217;
         default: return 19'd868;
      endcase
   endfunction

   state_t      state_q, state_d;
   logic        rx_meta_q, rx_s_q;
   logic [18:0] cnt_q, cnt_d;
   logic [2:0]  bits_q, bits_d;
   logic [7:0]  shift_q, shift_d;
   logic        par_q, par_d;
   logic        perr_n_q, perr_n_d;
   logic        ferr_n_q, ferr_n_d;
   logic [3:0]  baud_q, baud_d;
   logic        eight_q, eight_d;
   logic        pen_q, pen_d;
   logic        ohel_q, ohel_d;
   logic        armed_q, armed_d;
   logic [7:0]  data_q, data_d;
   logic        rdy_q, rdy_d;
   logic        perr_q, perr_d;
   logic        ferr_q, ferr_d;
   logic        ovf_q, ovf_d;

   logic [18:0] bit_time;
   logic [18:0] half_time;
   logic        bit_tick;
   logic        half_tick;
   logic [2:0]  last_bit;

   assign bit_time  = bit_time_f(baud_q);
   assign half_time = bit_time >> 1;
   assign bit_tick  = (cnt_q == bit_time - 19'd1);
   assign half_tick = (cnt_q == half_time - 19'd1);
   assign last_bit  = eight_q ? 3'd7 : 3'd6;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= RX;
         rx_s_q    <= rx_meta_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         bits_q   <= '0;
         shift_q  <= '0;
         par_q    <= 1'b0;
         perr_n_q <= 1'b0;
         ferr_n_q <= 1'b0;
         baud_q   <= '0;
         eight_q  <= 1'b0;
         pen_q    <= 1'b0;
         ohel_q   <= 1'b0;
         armed_q  <= 1'b1;
         data_q   <= '0;
         rdy_q    <= 1'b0;
         perr_q   <= 1'b0;
         ferr_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bits_q   <= bits_d;
         shift_q  <= shift_d;
         par_q    <= par_d;
         perr_n_q <= perr_n_d;
         ferr_n_q <= ferr_n_d;
         baud_q   <= baud_d;
         eight_q  <= eight_d;
         pen_q    <= pen_d;
         ohel_q   <= ohel_d;
         armed_q  <= armed_d;
         data_q   <= data_d;
         rdy_q    <= rdy_d;
         perr_q   <= perr_d;
         ferr_q   <= ferr_d;
         ovf_q    <= ovf_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + 19'd1;
      bits_d   = bits_q;
      shift_d  = shift_q;
      par_d    = par_q;
      perr_n_d = perr_n_q;
      ferr_n_d = ferr_n_q;
      baud_d   = baud_q;
      eight_d  = eight_q;
      pen_d    = pen_q;
      ohel_d   = ohel_q;
      armed_d  = armed_q;
      data_d   = data_q;
      rdy_d    = rdy_q;
      perr_d   = perr_q;
      ferr_d   = ferr_q;
      ovf_d    = ovf_q;

      // A READ acknowledge clears status; a completing frame in DONE overrides it.
      if (bus.READ) begin
         rdy_d  = 1'b0;
         perr_d = 1'b0;
         ferr_d = 1'b0;
         ovf_d  = 1'b0;
      end

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (rx_s_q) begin
               armed_d = 1'b1;
            end else if (armed_q) begin
               baud_d  = BAUD;
               eight_d = EIGHT;
               pen_d   = PEN;
               ohel_d  = OHEL;
               state_d = START;
            end
         end
         START: begin
            if (half_tick) begin
               cnt_d    = '0;
               bits_d   = '0;
               shift_d  = '0;
               par_d    = 1'b0;
               perr_n_d = 1'b0;
               ferr_n_d = 1'b0;
               state_d  = rx_s_q ? IDLE : DATA;
            end
         end
         DATA: begin
            if (bit_tick) begin
               cnt_d   = '0;
               shift_d = {rx_s_q, shift_q[7:1]};
               par_d   = par_q ^ rx_s_q;
               bits_d  = bits_q + 3'd1;
               if (bits_q == last_bit) begin
                  state_d = pen_q ? PARITY : STOP;
               end
            end
         end
         PARITY: begin
            if (bit_tick) begin
               cnt_d    = '0;
               perr_n_d = ((par_q ^ rx_s_q) != ohel_q);
               state_d  = STOP;
            end
         end
         STOP: begin
            if (bit_tick) begin
               cnt_d    = '0;
               ferr_n_d = ~rx_s_q;
               state_d  = DONE;
            end
         end
         DONE: begin
            cnt_d   = '0;
            data_d  = eight_q ? shift_q : {1'b0, shift_q[7:1]};
            rdy_d   = 1'b1;
            perr_d  = perr_n_q;
            ferr_d  = ferr_n_q;
            ovf_d   = rdy_q & ~bus.READ;
            armed_d = 1'b0;
            state_d = IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   assign bus.UART_DATA = data_q;
   assign bus.RXRDY     = rdy_q;
   assign bus.PERR      = perr_q;
   assign bus.FERR      = ferr_q;
   assign bus.OVF       = ovf_q;
endmodule

// File: tb/tb_uart_rx_engine.sv
// Self-checking bench for uart_rx_engine: directed and random serial frames scored
// against a frame-level reference model of the receiver's flags and data.
module tb_uart_rx_engine;
   logic       clk = 1'b0;
   logic       reset;
   logic       RX;
   logic [3:0] BAUD;
   logic       EIGHT;
   logic       PEN;
   logic       OHEL;

   uart_rx_engine_if bus();

   uart_rx_engine dut (
      .clk   (clk),
      .reset (reset),
      .RX    (RX),
      .BAUD  (BAUD),
      .EIGHT (EIGHT),
      .PEN   (PEN),
      .OHEL  (OHEL),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   int bt_tab[16] = '{333333, 166667, 83333, 41667, 20833, 10417, 5208, 2604,
                      1736, 868, 434, 217, 868, 868, 868, 868};

   // Reference model of the processor-visible state.
   logic [7:0] m_data = 8'h00;
   logic       m_rdy  = 1'b0;
   logic       m_perr = 1'b0;
   logic       m_ferr = 1'b0;
   logic       m_ovf  = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".data"}, {24'd0, bus.UART_DATA}, {24'd0, m_data});
      check({tag, ".rxrdy"}, {31'd0, bus.RXRDY}, {31'd0, m_rdy});
      check({tag, ".perr"}, {31'd0, bus.PERR}, {31'd0, m_perr});
      check({tag, ".ferr"}, {31'd0, bus.FERR}, {31'd0, m_ferr});
      check({tag, ".ovf"}, {31'd0, bus.OVF}, {31'd0, m_ovf});
   endtask

   // Drives nb bits LSB first, bt cycles each, starting at the next falling clock edge.
   // rise = cycles from the start-bit edge until RXRDY was first seen rising (-1: never).
   task automatic send_bits(input logic [11:0] bits, input int nb, input int bt,
                            input int limit, input int read_at, output int rise);
      logic prev;
      int   i;
      rise = -1;
      prev = bus.RXRDY;
      for (i = 0; i < nb * bt + 8; i++) begin
         @(negedge clk);
         if (bus.RXRDY && !prev && rise < 0) rise = i;
         prev = bus.RXRDY;
         if (limit > 0 && i == limit) return;
         bus.READ = (i == read_at);
         RX = (i < nb * bt) ? bits[i / bt] : 1'b1;
         if (i == 2 * bt) begin
            BAUD  = 4'($urandom);
            EIGHT = 1'($urandom);
            PEN   = 1'($urandom);
            OHEL  = 1'($urandom);
         end
      end
      bus.READ = 1'b0;
   endtask

   task automatic run_frame(input logic [7:0] d, input logic eight, input logic pen,
                            input logic ohel, input logic pbit, input logic stop,
                            input int code, input logic read_in_done, input string tag);
      int          bt;
      int          nd;
      int          nb;
      int          lat;
      int          rise;
      logic [11:0] bits;
      logic [7:0]  ed;
      logic        was_rdy;
      bt = bt_tab[code];
      nd = eight ? 8 : 7;
      nb = 1 + nd + (pen ? 1 : 0) + 1;
      bits = '1;
      bits[0] = 1'b0;
      for (int k = 0; k < nd; k++) bits[1 + k] = d[k];
      if (pen) bits[1 + nd] = pbit;
      bits[nb - 1] = stop;
      ed = eight ? d : {1'b0, d[6:0]};
      // RX->rx_s is 2 flops, detection takes 1 more; DONE follows the stop sample.
      lat = 3 + bt / 2 + (nb - 1) * bt + 1;

      BAUD  = 4'(code);
      EIGHT = eight;
      PEN   = pen;
      OHEL  = ohel;
      was_rdy = m_rdy;
      send_bits(bits, nb, bt, 0, read_in_done ? lat - 1 : -1, rise);

      m_data = ed;
      m_perr = pen && (((^ed) ^ pbit) != ohel);
      m_ferr = !stop;
      m_ovf  = was_rdy && !read_in_done;
      m_rdy  = 1'b1;
      if (!was_rdy) check({tag, ".latency"}, rise, lat);
      check_outputs(tag);
   endtask

   task automatic do_read(input string tag);
      @(negedge clk);
      bus.READ = 1'b1;
      @(negedge clk);
      bus.READ = 1'b0;
      m_rdy  = 1'b0;
      m_perr = 1'b0;
      m_ferr = 1'b0;
      m_ovf  = 1'b0;
      check_outputs(tag);
   endtask

   initial begin
      int          rise;
      logic [11:0] bits;
      reset    = 1'b1;
      RX       = 1'b1;
      BAUD     = 4'd9;
      EIGHT    = 1'b1;
      PEN      = 1'b0;
      OHEL     = 1'b0;
      bus.READ = 1'b0;

      #3 reset = 1'b0;
      #1 check_outputs("reset");
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check_outputs("post_reset");

      run_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 9, 1'b0, "a5_8n1");
      do_read("a5_read");

      run_frame(8'h41, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 11, 1'b0, "41_odd_ok");
      do_read("41_read1");
      run_frame(8'h41, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 11, 1'b0, "41_odd_bad");
      do_read("41_read2");

      run_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9, 1'b0, "3c_ferr");
      do_read("3c_read");

      // Glitch shorter than half a bit: must be rejected as a false start.
      BAUD = 4'd9;
      @(negedge clk);
      RX = 1'b0;
      repeat (200) @(negedge clk);
      RX = 1'b1;
      repeat (600) @(negedge clk);
      check_outputs("false_start");
      run_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 11, 1'b0, "after_glitch");

      for (int n = 0; n < 8; n++) begin
         logic [7:0] d;
         logic       e, p, o, pb, st;
         int         code;
         d    = 8'($urandom);
         e    = 1'($urandom);
         p    = 1'($urandom);
         o    = 1'($urandom);
         pb   = 1'($urandom);
         st   = ($urandom_range(0, 5) != 0);
         code = ($urandom_range(0, 3) == 0) ? 10 : 11;
         if (m_rdy && $urandom_range(0, 1) == 1) do_read($sformatf("rnd%0d_read", n));
         run_frame(d, e, p, o, pb, st, code, 1'b0, $sformatf("rnd%0d", n));
      end

      if (m_rdy) do_read("pre_ovf_read");
      run_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 11, 1'b0, "ovf_first");
      run_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 11, 1'b0, "ovf_second");
      run_frame(8'h44, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 11, 1'b1, "read_in_done");

      // Abort a frame with reset in the middle of data bit 4; outputs hold RXRDY=1 here.
      BAUD  = 4'd9;
      EIGHT = 1'b1;
      PEN   = 1'b0;
      bits  = {2'b11, 8'h5A, 1'b0, 1'b0};
      bits  = bits >> 1;
      send_bits(bits, 10, 868, 5 * 868 + 434, -1, rise);
      #2 reset = 1'b0;
      #1;
      m_data = 8'h00;
      m_rdy  = 1'b0;
      m_perr = 1'b0;
      m_ferr = 1'b0;
      m_ovf  = 1'b0;
      check_outputs("reset_midframe");
      RX = 1'b1;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      repeat (4) @(negedge clk);
      check_outputs("after_reset_idle");
      run_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 9, 1'b0, "5a_after_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_rx_engine.md
UART_RX_ENGINE -- requirements
Module: uart_rx_engine

Interface
REQ-001 SHALL have: clk  input  1  system clock, 100 MHz.
REQ-002 SHALL have: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have: RX  input  1  serial line, asynchronous to clk, idles high.
REQ-004 SHALL have: BAUD  input  4  baud-rate select code.
REQ-005 SHALL have: EIGHT  input  1  1 = 8 data bits, 0 = 7 data bits.
REQ-006 SHALL have: PEN  input  1  parity enable.
REQ-007 SHALL have: OHEL  input  1  parity sense: 1 = odd, 0 = even.
REQ-008 SHALL have: READ  input  1  one-cycle pulse from the processor that acknowledges the received byte.
REQ-009 SHALL have: UART_DATA  output  8  last received byte.
REQ-010 SHALL have: RXRDY  output  1  a byte is available.
REQ-011 SHALL have: PERR, FERR, OVF  output  1 each  parity, framing and overrun error flags.

Function
REQ-012 SHALL pass RX through a 2-flop synchronizer (reset value 1); all logic below uses the synchronized value rx_s.
REQ-013 SHALL map BAUD to bit_time in clk cycles as follows:
  - 0=333333, 1=166667, 2=83333, 3=41667, 4=20833, 5=10417
  - 6=5208, 7=2604, 8=1736, 9=868, 10=434, 11=217
  - 12..15 = 868
REQ-014 SHALL set half_time = floor(bit_time/2); the bit counter SHALL be 19 bits wide.
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP, DONE.
REQ-016 IDLE: on the first cycle T with rx_s=0, SHALL latch BAUD/EIGHT/PEN/OHEL, clear the counter and go to START; input changes mid-frame SHALL be ignored.
REQ-017 START: at T+half_time SHALL sample rx_s.
  - rx_s=1 (false start): go to IDLE with no flag change.
  - rx_s=0: go to DATA.
REQ-018 DATA: SHALL sample every bit_time cycles, shifting LSB first.
  - Samples 7 (EIGHT=0) or 8 (EIGHT=1) bits.
  - With 7 bits, data bit 7 SHALL be 0.
REQ-019 PARITY (only if PEN=1): SHALL sample one bit_time after the last data bit.
  - perr_n = 1 if XOR(received data bits, parity bit) differs from OHEL.
REQ-020 STOP: SHALL sample one bit_time after the previous sample.
  - ferr_n = (sample == 0).
REQ-021 The stop sample SHALL occur at cycle T+half_time+N*bit_time, with N = data bits + PEN + 1.
REQ-022 DONE (one cycle, the cycle after the stop sample) SHALL load UART_DATA and set RXRDY=1, PERR=perr_n and FERR=ferr_n, then return to IDLE.
REQ-023 Overrun: if RXRDY=1 and READ=0 in DONE, SHALL set OVF=1 and overwrite UART_DATA.
REQ-024 READ=1 outside DONE SHALL clear RXRDY, PERR, FERR and OVF on the next edge.
REQ-025 READ=1 in the DONE cycle: completion wins.
  - RXRDY=1, new PERR/FERR loaded, OVF=0.
REQ-026 After DONE, IDLE SHALL not detect a new start until rx_s has been 1 for at least one cycle (no re-trigger on a held-low line).
REQ-027 UART_DATA and the flags SHALL be stable between DONE events; flags SHALL never change mid-frame.

Reset
REQ-028 On reset=0, immediately and regardless of clk, SHALL reset to:
  - state=IDLE, counters=0, synchronizer=1
  - UART_DATA=8'h00, RXRDY=0, PERR=0, FERR=0, OVF=0
REQ-029 Reset asserted mid-frame SHALL abort the frame; after release the block SHALL wait for a new falling edge.

Verification
REQ-030 BAUD=9, EIGHT=1, PEN=0; send 0xA5 8N1; first rx_s=0 at T -> stop sample at T+8246, RXRDY=1 and UART_DATA=8'hA5 at T+8247, PERR=FERR=OVF=0.
REQ-031 BAUD=11, EIGHT=0, PEN=1, OHEL=1; send 7'h41 with parity bit 1 -> UART_DATA=8'h41, PERR=0; repeat with parity bit 0 -> PERR=1.
REQ-032 BAUD=9, 8N1, send 0x3C with stop bit 0 -> FERR=1, UART_DATA=8'h3C; READ pulse -> RXRDY=FERR=0 next cycle.
REQ-033 Two frames 0x11 then 0x22 with no READ -> UART_DATA=8'h22, RXRDY=1, OVF=1; READ coincident with 2nd DONE -> OVF=0.
REQ-034 RX low pulse of 200 cycles at BAUD=9 -> no RXRDY, state back to IDLE at T+434.
REQ-035 Assert reset at mid-data bit 4 -> all outputs 0 immediately; a subsequent clean 0x5A frame is received correctly.
